// File: rtl/bcd_to_binary_seq.sv
// Sequential packed-BCD to unsigned binary converter, one digit per clock, MSD first.
// Optional digit validity checking is enabled by defining BCD2BIN_DIGIT_CHECK_EN.
module bcd_to_binary_seq #(
  parameter int DIGITS = 2,
  parameter int BW     = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic [BW-1:0]         bin,
  output logic                  err
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = 4;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [BW-1:0]   acc_q, acc_d;
  logic [BW-1:0]   acc_next;
  logic [CW-1:0]   count_q, count_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [BW-1:0]   bin_q, bin_d;
  logic [3:0]      digit;

`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic            inv_q, inv_d;
  logic            inv_final;

  function automatic logic digit_invalid(input logic [3:0] d);
    return d[3] & (d[2] | d[1]);
  endfunction
`endif

  // Next-state logic: acc*10 is formed as (acc<<3)+(acc<<1), modulo 2^BW
  always_comb begin
    digit    = shift_q[W-1 -: 4];
    acc_next = (acc_q << 3) + (acc_q << 1) + BW'(digit);
    state_d  = state_q;
    shift_d  = shift_q;
    acc_d    = acc_q;
    count_d  = count_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    bin_d    = bin_q;
`ifdef BCD2BIN_DIGIT_CHECK_EN
    inv_d     = inv_q;
    inv_final = inv_q | digit_invalid(digit);
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = bcd;
          acc_d   = '0;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = CONV;
`ifdef BCD2BIN_DIGIT_CHECK_EN
          inv_d   = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      CONV: begin
        acc_d   = acc_next;
        shift_d = shift_q << 4;
        count_d = count_q + 4'd1;
`ifdef BCD2BIN_DIGIT_CHECK_EN
        inv_d   = inv_final;
`endif
        if (count_q == CW'(DIGITS - 1)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
`ifdef BCD2BIN_DIGIT_CHECK_EN
          err_d   = inv_final;
          bin_d   = inv_final ? '0 : acc_next;
`else
          err_d   = 1'b0;
          bin_d   = acc_next;
`endif
        end else begin
          state_d = CONV;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      acc_q   <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      bin_q   <= '0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      bin_q   <= bin_d;
`ifdef BCD2BIN_DIGIT_CHECK_EN
      inv_q   <= inv_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bin  = bin_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Randomized self-checking bench for bcd_to_binary_seq (2-digit and 3-digit instances).
module tb_bcd_to_binary_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start2, start3;
  logic [7:0]  bcd2;
  logic [11:0] bcd3;
  logic        busy2, done2, err2;
  logic [6:0]  bin2;
  logic        busy3, done3, err3;
  logic [9:0]  bin3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_to_binary_seq #(.DIGITS(2), .BW(7)) dut (
    .clk(clk), .reset(reset), .start(start2), .bcd(bcd2),
    .busy(busy2), .done(done2), .bin(bin2), .err(err2)
  );

  bcd_to_binary_seq #(.DIGITS(3), .BW(10)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .bcd(bcd3),
    .busy(busy3), .done(done3), .bin(bin3), .err(err3)
  );

  // Reference: decimal value of the digit string, modulo 2^bw
  function automatic void model(input int nd, input int bw, input int val,
                                output int exp_bin, output bit exp_err);
    int v;
    bit bad;
    v = 0;
    bad = 1'b0;
    for (int i = nd - 1; i >= 0; i--) begin
      int d;
      d = (val >> (4 * i)) & 15;
      if (d > 9) bad = 1'b1;
      v = v * 10 + d;
    end
    v = v % (1 << bw);
`ifdef BCD2BIN_DIGIT_CHECK_EN
    exp_err = bad;
    exp_bin = bad ? 0 : v;
`else
    exp_err = 1'b0;
    exp_bin = v;
`endif
  endfunction

  // Called at a negedge; pulses start for one cycle and waits for done
  task automatic convert(input int which, input logic [11:0] val,
                         output int got_bin, output bit got_err, output int lat,
                         output bit busy_ok, output bit held);
    int prev;
    bit seen;
    prev = (which == 3) ? int'(bin3) : int'(bin2);
    busy_ok = 1'b1;
    held = 1'b1;
    lat = 0;
    seen = 1'b0;
    got_bin = -1;
    got_err = 1'b0;
    if (which == 3) begin
      bcd3 = val;
      start3 = 1'b1;
    end else begin
      bcd2 = val[7:0];
      start2 = 1'b1;
    end
    while (!seen && lat < 12) begin
      @(negedge clk);
      lat++;
      start2 = 1'b0;
      start3 = 1'b0;
      if (which == 3) begin
        if (done3) begin
          seen = 1'b1; got_bin = int'(bin3); got_err = err3;
          if (busy3) busy_ok = 1'b0;
        end else begin
          if (!busy3) busy_ok = 1'b0;
          if (int'(bin3) != prev) held = 1'b0;
        end
      end else begin
        if (done2) begin
          seen = 1'b1; got_bin = int'(bin2); got_err = err2;
          if (busy2) busy_ok = 1'b0;
        end else begin
          if (!busy2) busy_ok = 1'b0;
          if (int'(bin2) != prev) held = 1'b0;
        end
      end
    end
    if (!seen) lat = -1;
  endtask

  task automatic check_conv(input string name, input int which, input int val);
    int gb, lat, eb;
    bit ge, bok, hld, ee;
    int nd, bw;
    nd = (which == 3) ? 3 : 2;
    bw = (which == 3) ? 10 : 7;
    model(nd, bw, val, eb, ee);
    convert(which, 12'(val), gb, ge, lat, bok, hld);
    checks++;
    if (lat !== nd + 1) begin
      errors++; $display("FAIL %s latency: got %0d expected %0d", name, lat, nd + 1);
    end
    checks++;
    if (gb !== eb) begin
      errors++; $display("FAIL %s bin (bcd=%h): got %0d expected %0d", name, val, gb, eb);
    end
    checks++;
    if (ge !== ee) begin
      errors++; $display("FAIL %s err (bcd=%h): got %0d expected %0d", name, val, ge, ee);
    end
    checks++;
    if (bok !== 1'b1 || hld !== 1'b1) begin
      errors++; $display("FAIL %s busy/hold: got busy_ok=%0d held=%0d expected 1 1", name, bok, hld);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start2 = 1'b0; start3 = 1'b0; bcd2 = 8'h00; bcd3 = 12'h000;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy2, done2, err2, bin2} !== 10'd0 || {busy3, done3, err3, bin3} !== 13'd0) begin
      errors++;
      $display("FAIL reset_state: got %b/%b expected all zero", {busy2, done2, err2, bin2}, {busy3, done3, err3, bin3});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    check_conv("basic_47", 2, 32'h47);
    @(negedge clk);
    checks++;
    if (done2 !== 1'b0 || bin2 !== 7'd47) begin
      errors++; $display("FAIL basic_hold: got done=%0d bin=%0d expected 0 47", done2, bin2);
    end
  endtask

  task automatic test_back_to_back();
    check_conv("b2b_99", 2, 32'h99);
    check_conv("b2b_00", 2, 32'h00);
  endtask

  task automatic test_ignore_busy();
    int ndone, lastbin;
    ndone = 0; lastbin = -1;
    bcd2 = 8'h12; start2 = 1'b1;
    @(negedge clk);
    bcd2 = 8'h34; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0; bcd2 = 8'h77;
    if (done2) begin ndone++; lastbin = int'(bin2); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done2) begin ndone++; lastbin = int'(bin2); end
    end
    checks++;
    if (ndone !== 1) begin
      errors++; $display("FAIL ignore_done_count: got %0d expected 1", ndone);
    end
    checks++;
    if (lastbin !== 12) begin
      errors++; $display("FAIL ignore_bin: got %0d expected 12", lastbin);
    end
  endtask

  task automatic test_reset_abort();
    int ndone;
    ndone = 0;
    bcd2 = 8'h56; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (busy2 !== 1'b0 || bin2 !== 7'd0 || done2 !== 1'b0) begin
      errors++; $display("FAIL abort_state: got busy=%0d bin=%0d done=%0d expected 0 0 0", busy2, bin2, done2);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done2 || busy2 || bin2 != 7'd0) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++; $display("FAIL abort_quiet: got %0d active cycles expected 0", ndone);
    end
  endtask

  task automatic test_invalid_digit();
    check_conv("invalid_3A", 2, 32'h3A);
  endtask

  task automatic test_three_digit();
    check_conv("three_999", 3, 32'h999);
    check_conv("three_100", 3, 32'h100);
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      int val, nd, which;
      which = (n % 2 == 0) ? 2 : 3;
      nd = which;
      val = 0;
      for (int i = 0; i < nd; i++) begin
        int d;
        d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
        val = (val << 4) | d;
      end
      check_conv("random", which, val);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore_busy();
    test_reset_abort();
    test_invalid_digit();
    test_three_digit();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_to_binary_seq.md
Name: bcd_to_binary_seq

Overview:
- Sequential converter from multi-digit packed BCD to unsigned binary.
- Performs the reverse of the team's binary-to-BCD display path. It feeds switch-entered decimal operands into binary arithmetic blocks.
- Processes one decimal digit per clock, most significant digit first, using acc = acc*10 + digit.
- Uses a start/busy/done handshake.

Parameters:
- DIGITS, 2, number of BCD digits in the input word (1..8).
- BW, 7, binary output width. Must satisfy 2^BW >= 10^DIGITS (e.g. 7 for 2 digits, 10 for 3).

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  conversion request, sampled only in IDLE.
- bcd  input  4*DIGITS  packed BCD. bcd[4*DIGITS-1 -: 4] is the most significant digit.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse marking the cycle in which a new bin is first valid.
- bin  output  BW  converted result. Holds its value until the next completion.
- err  output  1  invalid-digit flag. Valid with done and held alongside bin. See Optional Feature.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, busy=0, done=0, bin=0, err=0, internal acc/shift/count=0.
- States: IDLE, CONV.
- IDLE:
  - On the rising edge where start=1: latch bcd into the shift register, clear acc and count, set state=CONV and busy=1.
  - start=0 leaves the state unchanged.
- CONV, on each edge:
  - acc <= (acc<<3) + (acc<<1) + top digit of the shift register, truncated to BW bits.
  - Shift register moves left by 4.
  - count increments.
- Completion: on the edge where count reaches DIGITS-1 (the DIGITS-th accumulate edge):
  - bin <= final acc value.
  - done <= 1, busy <= 0, state <= IDLE.
- Latency: start sampled at edge k gives bin valid and done=1 in the cycle after edge k+DIGITS. Throughput is one conversion per DIGITS+1 cycles.
- done is high for exactly one cycle per conversion.
- start while busy=1 is ignored: no queueing, and the latched bcd is unaffected by later bcd changes.
- start=1 during the done cycle is accepted, because the state is already IDLE.
- bin and err change only on a completion edge or on reset, never mid-conversion.
- Reset mid-conversion aborts it: no done pulse, and bin returns to 0.
- Arithmetic is modulo 2^BW. With legal digits and a legal BW, no truncation occurs.

Optional Feature:
- Macro: BCD2BIN_DIGIT_CHECK_EN.
- Defined:
  - Each digit consumed in CONV is checked for >9, i.e. d[3]&(d[2]|d[1]).
  - A sticky invalid bit is cleared at start acceptance.
  - At completion: err <= invalid bit. If invalid, bin <= 0 instead of acc.
- Undefined:
  - No checking; err is held at 0.
  - Digits 10..15 are accumulated arithmetically as their binary value.

Test Plan (DIGITS=2, BW=7 unless stated):
- Reset, then start with bcd=0x47 for one cycle -> busy=1 for 2 cycles, then done=1 for one cycle with bin=7'd47 (0x2F), err=0. bin holds 47 afterwards.
- bcd=0x99, then bcd=0x00 back-to-back, with start reasserted during the done cycle -> bin=99 (0x63), then bin=0, each with its own single done pulse.
- start with bcd=0x12, then next cycle start with bcd=0x34 (ignored) -> exactly one done, bin=12.
- start with bcd=0x56, assert reset the next cycle -> busy=0, bin=0, and no done pulse for 3+ cycles after reset release.
- bcd=0x3A: with BCD2BIN_DIGIT_CHECK_EN -> err=1, bin=0. Without it -> err=0, bin=40.
- DIGITS=3, BW=10, bcd=0x999 -> done 3 cycles after start, bin=10'd999.
